hack_alu_stage: RTL and testbench

Registered Hack ALU stage with valid/ready handshake on both sides and a 2-entry output buffer. It consumes operand pairs `x`, `y` and a 6-bit Hack control word, computes the Hack ALU function using the 16-bit bitwise AND gate as its AND path, and presents `out`, `zr` and `ng` to the downstream consumer. It sits between operand fetch (A/D/M select) and register write-back. It sustains one result per cycle when downstream is ready.

---
 rtl/hack_alu_stage.sv | 148 ++++++++++++++
 tb/tb_hack_alu_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hack_alu_stage.sv
// hack_alu_stage: registered Hack ALU with valid/ready handshakes and a
// 2-entry output FIFO. Optional macro HACK_ALU_STAGE_CARRY_EN adds the
// adder carry-out (cy) to every stored entry and to the output port.
module hack_alu_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
`ifdef HACK_ALU_STAGE_CARRY_EN
    ,
    output logic             cy
`endif
);

    localparam int unsigned DEPTH = 2;

    logic [WIDTH-1:0] w_x1, w_x2, w_y1, w_y2, w_o, w_r;
    logic             w_zr, w_ng;
`ifdef HACK_ALU_STAGE_CARRY_EN
    logic [WIDTH:0]   w_sum;
    logic             w_cy;
    logic             r_mem_cy [DEPTH];
    logic             r_cy;
`else
    logic [WIDTH-1:0] w_sum;
`endif

    logic [WIDTH-1:0] r_mem_r  [DEPTH];
    logic             r_mem_zr [DEPTH];
    logic             r_mem_ng [DEPTH];
    logic             r_wptr, r_rptr;
    logic [1:0]       r_count;
    logic             r_in_ready, r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_zr, r_ng;

    logic             w_push, w_pop, w_head_new;
    logic             w_wptr_n, w_rptr_n;
    logic [1:0]       w_count_n;

    // Hack ALU datapath and result flags for the offered operands
    always_comb begin
        w_x1 = ctrl[5] ? '0 : x;
        w_x2 = ctrl[4] ? ~w_x1 : w_x1;
        w_y1 = ctrl[3] ? '0 : y;
        w_y2 = ctrl[2] ? ~w_y1 : w_y1;
`ifdef HACK_ALU_STAGE_CARRY_EN
        w_sum = {1'b0, w_x2} + {1'b0, w_y2};
        w_cy  = ctrl[1] & w_sum[WIDTH];
        w_o   = ctrl[1] ? w_sum[WIDTH-1:0] : (w_x2 & w_y2);
`else
        w_sum = w_x2 + w_y2;
        w_o   = ctrl[1] ? w_sum : (w_x2 & w_y2);
`endif
        w_r  = ctrl[0] ? ~w_o : w_o;
        w_zr = (w_r == '0);
        w_ng = w_r[WIDTH-1];
    end

    // Handshake decode and next pointer/occupancy values
    always_comb begin
        w_push    = in_valid & r_in_ready;
        w_pop     = r_out_valid & out_ready;
        w_wptr_n  = r_wptr ^ w_push;
        w_rptr_n  = r_rptr ^ w_pop;
        w_count_n = r_count;
        if (w_push && !w_pop)
            w_count_n = r_count + 2'd1;
        else if (!w_push && w_pop)
            w_count_n = r_count - 2'd1;
        // The new entry becomes the head when it lands where the read pointer points next
        w_head_new = w_push & (r_wptr == w_rptr_n);
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_r[i]  <= '0;
                r_mem_zr[i] <= 1'b0;
                r_mem_ng[i] <= 1'b0;
`ifdef HACK_ALU_STAGE_CARRY_EN
                r_mem_cy[i] <= 1'b0;
`endif
            end
        end else begin
            r_wptr  <= w_wptr_n;
            r_rptr  <= w_rptr_n;
            r_count <= w_count_n;
            if (w_push) begin
                r_mem_r[r_wptr]  <= w_r;
                r_mem_zr[r_wptr] <= w_zr;
                r_mem_ng[r_wptr] <= w_ng;
`ifdef HACK_ALU_STAGE_CARRY_EN
                r_mem_cy[r_wptr] <= w_cy;
`endif
            end
        end
    end

    // Registered handshake flags and head-entry outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_zr        <= 1'b0;
            r_ng        <= 1'b0;
`ifdef HACK_ALU_STAGE_CARRY_EN
            r_cy        <= 1'b0;
`endif
        end else begin
            r_in_ready  <= (w_count_n != 2'd2);
            r_out_valid <= (w_count_n != 2'd0);
            if (w_count_n != 2'd0) begin
                r_out <= w_head_new ? w_r  : r_mem_r[w_rptr_n];
                r_zr  <= w_head_new ? w_zr : r_mem_zr[w_rptr_n];
                r_ng  <= w_head_new ? w_ng : r_mem_ng[w_rptr_n];
`ifdef HACK_ALU_STAGE_CARRY_EN
                r_cy  <= w_head_new ? w_cy : r_mem_cy[w_rptr_n];
`endif
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign zr        = r_zr;
    assign ng        = r_ng;
`ifdef HACK_ALU_STAGE_CARRY_EN
    assign cy        = r_cy;
`endif

endmodule

// File: tb/tb_hack_alu_stage.sv
// Testbench for hack_alu_stage: directed table, backpressure, streaming,
// reset-mid-operation and randomized traffic against a queue-based model.
module tb_hack_alu_stage;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x, y;
    logic [5:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr, ng;
`ifdef HACK_ALU_STAGE_CARRY_EN
    logic             cy;
`endif

    always #5 clk = ~clk;

    hack_alu_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng)
`ifdef HACK_ALU_STAGE_CARRY_EN
        ,
        .cy        (cy)
`endif
    );

    typedef struct {
        logic [15:0] out;
        logic        zr;
        logic        ng;
        logic        cy;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  c;
        logic [15:0] eo;
        logic        ezr;
        logic        eng;
    } vec_t;

    exp_t q[$];
    vec_t tbl[10];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hack ALU computed with integer arithmetic: negation as 65535 - v
    function automatic exp_t alu_ref(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
        exp_t        e;
        int unsigned xa, yb, o;
        xa = c[5] ? 0 : int'(a);
        if (c[4]) xa = 65535 - xa;
        yb = c[3] ? 0 : int'(b);
        if (c[2]) yb = 65535 - yb;
        if (c[1]) begin
            o    = xa + yb;
            e.cy = (o > 65535);
            o    = o % 65536;
        end else begin
            o    = xa & yb;
            e.cy = 1'b0;
        end
        if (c[0]) o = 65535 - o;
        e.out = 16'(o);
        e.zr  = (o == 0);
        e.ng  = (o >= 32768);
        return e;
    endfunction

    // One clock of traffic checked against the queue model; call just after an edge
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [5:0] c, input logic ordy, input string tag);
        logic push, pop;
        in_valid  = v;
        x         = a;
        y         = b;
        ctrl      = c;
        out_ready = ordy;
        check({tag, " in_ready"}, 32'(in_ready), 32'(q.size() != 2));
        check({tag, " out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check({tag, " out"}, 32'(out), 32'(q[0].out));
            check({tag, " zr"}, 32'(zr), 32'(q[0].zr));
            check({tag, " ng"}, 32'(ng), 32'(q[0].ng));
`ifdef HACK_ALU_STAGE_CARRY_EN
            check({tag, " cy"}, 32'(cy), 32'(q[0].cy));
`endif
        end
        push = v && (q.size() < 2);
        pop  = (q.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(alu_ref(a, b, c));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        ctrl      = '0;

        tbl[0] = '{16'h0011, 16'h0003, 6'b000010, 16'h0014, 1'b0, 1'b0};
        tbl[1] = '{16'hFF00, 16'h0F0F, 6'b000000, 16'h0F00, 1'b0, 1'b0};
        tbl[2] = '{16'hFF00, 16'h0F0F, 6'b101010, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{16'h0003, 16'h0005, 6'b010011, 16'hFFFE, 1'b0, 1'b1};
        tbl[4] = '{16'h1234, 16'h5678, 6'b111111, 16'h0001, 1'b0, 1'b0};
        tbl[5] = '{16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1};
        tbl[6] = '{16'h1234, 16'h5678, 6'b001100, 16'h1234, 1'b0, 1'b0};
        tbl[7] = '{16'h1234, 16'h5678, 6'b001101, 16'hEDCB, 1'b0, 1'b1};
        tbl[8] = '{16'h0005, 16'h0003, 6'b000111, 16'hFFFE, 1'b0, 1'b1};
        tbl[9] = '{16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out", 32'(out), 32'd0);
        check("rst zr", 32'(zr), 32'd0);
        check("rst ng", 32'(ng), 32'd0);
        rst_n = 1'b1;

        // Directed table, one push per cycle with downstream ready
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            x         = tbl[i].x;
            y         = tbl[i].y;
            ctrl      = tbl[i].c;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("tbl%0d out", i), 32'(out), 32'(tbl[i].eo));
            check($sformatf("tbl%0d zr", i), 32'(zr), 32'(tbl[i].ezr));
            check($sformatf("tbl%0d ng", i), 32'(ng), 32'(tbl[i].eng));
            check($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain out_valid", 32'(out_valid), 32'd0);

`ifdef HACK_ALU_STAGE_CARRY_EN
        // Carry-out of the adder with wrap to zero
        in_valid = 1'b1;
        x        = 16'hFFFF;
        y        = 16'h0001;
        ctrl     = 6'b000010;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("carry out", 32'(out), 32'h0000);
        check("carry zr", 32'(zr), 32'd1);
        check("carry cy", 32'(cy), 32'd1);
        @(posedge clk);
        #1;
`endif

        // Backpressure: A, B fill the buffer, C is held until A pops
        cycle(1'b1, 16'h0001, 16'h0002, 6'b000010, 1'b0, "bp A");
        cycle(1'b1, 16'h0010, 16'h0020, 6'b000010, 1'b0, "bp B");
        cycle(1'b1, 16'h0100, 16'h0200, 6'b000010, 1'b0, "bp C held");
        cycle(1'b1, 16'h0100, 16'h0200, 6'b000010, 1'b0, "bp C held2");
        check("bp full in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 16'h0100, 16'h0200, 6'b000010, 1'b1, "bp pop A");
        check("bp reopen in_ready", 32'(in_ready), 32'd1);
        check("bp head B", 32'(out), 32'h0030);
        cycle(1'b1, 16'h0100, 16'h0200, 6'b000010, 1'b1, "bp push C");
        check("bp head C", 32'(out), 32'h0300);
        cycle(1'b0, 16'h0000, 16'h0000, 6'b000000, 1'b1, "bp pop C");
        check("bp empty", 32'(out_valid), 32'd0);

        // Streaming: 8 back-to-back results
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 6'($urandom), 1'b1, $sformatf("stream%0d", i));
        cycle(1'b0, 16'h0000, 16'h0000, 6'b000000, 1'b1, "stream drain");

        // Reset mid-operation with the buffer full
        cycle(1'b1, 16'h1111, 16'h2222, 6'b000010, 1'b0, "mid A");
        cycle(1'b1, 16'h3333, 16'h4444, 6'b000010, 1'b0, "mid B");
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out", 32'(out), 32'd0);
        check("midrst zr", 32'(zr), 32'd0);
        check("midrst ng", 32'(ng), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
`ifdef HACK_ALU_STAGE_CARRY_EN
        check("midrst cy", 32'(cy), 32'd0);
`endif
        q.delete();
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 16'h0007, 16'h0009, 6'b000010, 1'b1, "post rst push");
        check("post rst out", 32'(out), 32'h0010);
        cycle(1'b0, 16'h0000, 16'h0000, 6'b000000, 1'b1, "post rst pop");

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 6'($urandom),
                  1'($urandom_range(0, 1)), $sformatf("rand%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
